vdma_write_mc_sched: RTL and testbench

VDMA_WRITE_MC_SCHED -- requirements
Module: vdma_write_mc_sched

---
 rtl/vdma_write_mc_sched.sv | 275 +++++++++++++++++++++++++++
 tb/tb_vdma_write_mc_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdma_write_mc_sched.sv
// Multi-channel VDMA write scheduler: per-channel frame FSMs feed a round-robin
// burst arbiter that drives one DDR write master and reports completed frames.
module vdma_write_mc_sched #(
  parameter int g_NUM_CH    = 2,
  parameter int g_OP_DW     = 64,
  parameter int g_BURST_LEN = 16,
  parameter int g_NUM_BUFF  = 3
) (
  input  logic                   aclk_i,
  input  logic                   aclk_rstn_i,
  input  logic                   vdma_ip_en_i,
  input  logic [g_NUM_CH-1:0]    ch_frame_start_i,
  input  logic [g_NUM_CH-1:0]    ch_frame_end_i,
  input  logic [g_NUM_CH*16-1:0] ch_level_i,
  input  logic                   buff_base_wr_i,
  input  logic [1:0]             buff_base_ch_i,
  input  logic [1:0]             buff_base_idx_i,
  input  logic [31:0]            buff_base_data_i,
  input  logic                   write_ackn_i,
  input  logic                   write_done_i,
  output logic                   write_req_o,
  output logic [7:0]             write_length_o,
  output logic [37:0]            write_start_addr_o,
  output logic [1:0]             write_ch_o,
  output logic                   frame_size_valid_o,
  output logic [1:0]             frame_size_ch_o,
  output logic [31:0]            frame_size_o,
  output logic [g_NUM_CH-1:0]    int_dma_o,
  output logic [g_NUM_CH*2-1:0]  cur_buff_idx_o
);
  localparam logic [15:0] LP_BURST    = 16'(g_BURST_LEN);
  localparam logic [37:0] LP_BPB      = 38'(g_OP_DW / 8);
  localparam logic [1:0]  LP_LAST_CH  = 2'(g_NUM_CH - 1);
  localparam logic [1:0]  LP_LAST_BUF = 2'(g_NUM_BUFF - 1);

  typedef enum logic [1:0] {CH_IDLE, CH_ACTIVE, CH_FLUSH} ch_state_e;
  typedef enum logic [1:0] {ST_ARB, ST_REQ, ST_WAIT_DONE} arb_state_e;

  ch_state_e   ch_state_q [4];
  ch_state_e   ch_state_d [4];
  logic [37:0] addr_q     [4];
  logic [37:0] addr_d     [4];
  logic [31:0] byte_cnt_q [4];
  logic [31:0] byte_cnt_d [4];
  logic [1:0]  cur_idx_q  [4];
  logic [1:0]  cur_idx_d  [4];
  logic [31:0] base_q     [4][4];
  logic [31:0] base_d     [4][4];
  logic [15:0] level_s    [4];

  arb_state_e    arb_q, arb_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    last_grant_q, last_grant_d;
  logic [8:0]    beats_q, beats_d;
  logic          write_req_q, write_req_d;
  logic [7:0]    write_length_q, write_length_d;
  logic [37:0]   write_addr_q, write_addr_d;
  logic [1:0]    write_ch_q, write_ch_d;
  logic          fs_valid_q, fs_valid_d;
  logic [1:0]    fs_ch_q, fs_ch_d;
  logic [31:0]   fs_size_q, fs_size_d;
  logic [g_NUM_CH-1:0] int_dma_q, int_dma_d;

  logic          found_s;
  logic          comp_found_s;
  logic [1:0]    comp_ch_s;
  logic [1:0]    rr_s;
  logic [2:0]    rr_sum_s;
  logic [37:0]   inc_s;

  // Per-channel FIFO levels and current buffer index flattened onto ports.
  always_comb begin
    cur_buff_idx_o = '0;
    for (int i = 0; i < 4; i++) begin
      level_s[i] = 16'd0;
    end
    for (int i = 0; i < g_NUM_CH; i++) begin
      level_s[i] = ch_level_i[16*i +: 16];
      cur_buff_idx_o[2*i +: 2] = cur_idx_q[i];
    end
  end

  // Next-state logic for base table, channel FSMs, arbiter and reporting.
  always_comb begin
    arb_d          = arb_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    beats_d        = beats_q;
    write_req_d    = write_req_q;
    write_length_d = write_length_q;
    write_addr_d   = write_addr_q;
    write_ch_d     = write_ch_q;
    fs_valid_d     = 1'b0;
    fs_ch_d        = fs_ch_q;
    fs_size_d      = fs_size_q;
    int_dma_d      = '0;
    found_s        = 1'b0;
    comp_found_s   = 1'b0;
    comp_ch_s      = 2'd0;
    rr_s           = 2'd0;
    rr_sum_s       = 3'd0;
    inc_s          = {29'd0, beats_q} * LP_BPB;
    for (int i = 0; i < 4; i++) begin
      ch_state_d[i] = ch_state_q[i];
      addr_d[i]     = addr_q[i];
      byte_cnt_d[i] = byte_cnt_q[i];
      cur_idx_d[i]  = cur_idx_q[i];
      for (int j = 0; j < 4; j++) begin
        base_d[i][j] = base_q[i][j];
      end
    end

    if (buff_base_wr_i && (int'(buff_base_ch_i) < g_NUM_CH) &&
        (int'(buff_base_idx_i) < g_NUM_BUFF)) begin
      base_d[buff_base_ch_i][buff_base_idx_i] = buff_base_data_i;
    end else begin
      base_d[0][0] = base_q[0][0];
    end

    for (int i = 0; i < g_NUM_CH; i++) begin
      case (ch_state_q[i])
        CH_IDLE: begin
          if (ch_frame_start_i[i] && vdma_ip_en_i) begin
            ch_state_d[i] = CH_ACTIVE;
            addr_d[i]     = {6'd0, base_q[i][cur_idx_q[i]]};
            byte_cnt_d[i] = 32'd0;
          end else begin
            ch_state_d[i] = CH_IDLE;
          end
        end
        CH_ACTIVE: ch_state_d[i] = ch_frame_end_i[i] ? CH_FLUSH : CH_ACTIVE;
        CH_FLUSH:  ch_state_d[i] = CH_FLUSH;
        default:   ch_state_d[i] = CH_IDLE;
      endcase
    end

    case (arb_q)
      ST_ARB: begin
        for (int k = 0; k < g_NUM_CH; k++) begin
          rr_sum_s = {1'b0, last_grant_q} + 3'd1 + 3'(k);
          if (rr_sum_s >= 3'(g_NUM_CH)) begin
            rr_sum_s = rr_sum_s - 3'(g_NUM_CH);
          end else begin
            rr_sum_s = rr_sum_s;
          end
          rr_s = rr_sum_s[1:0];
          if (!found_s &&
              (((ch_state_q[rr_s] == CH_ACTIVE) && (level_s[rr_s] >= LP_BURST)) ||
               ((ch_state_q[rr_s] == CH_FLUSH) && (level_s[rr_s] != 16'd0)))) begin
            found_s = 1'b1;
            grant_d = rr_s;
            // A flushing channel may hold less than a full burst.
            if ((ch_state_q[rr_s] == CH_FLUSH) && (level_s[rr_s] < LP_BURST)) begin
              beats_d = level_s[rr_s][8:0];
            end else begin
              beats_d = 9'(g_BURST_LEN);
            end
            arb_d          = ST_REQ;
            write_req_d    = 1'b1;
            write_length_d = 8'(beats_d - 9'd1);
            write_addr_d   = addr_q[rr_s];
            write_ch_d     = rr_s;
          end else begin
            found_s = found_s;
          end
        end
      end
      ST_REQ: begin
        if (write_ackn_i) begin
          arb_d       = ST_WAIT_DONE;
          write_req_d = 1'b0;
        end else begin
          arb_d = ST_REQ;
        end
      end
      ST_WAIT_DONE: begin
        if (write_done_i) begin
          addr_d[grant_q]     = addr_q[grant_q] + inc_s;
          byte_cnt_d[grant_q] = byte_cnt_q[grant_q] + inc_s[31:0];
          last_grant_d        = grant_q;
          arb_d               = ST_ARB;
        end else begin
          arb_d = ST_WAIT_DONE;
        end
      end
      default: begin
        arb_d       = ST_ARB;
        write_req_d = 1'b0;
      end
    endcase

    // The channel owning the in-flight burst cannot complete until it returns.
    for (int i = 0; i < g_NUM_CH; i++) begin
      if (!comp_found_s && (ch_state_q[i] == CH_FLUSH) && (level_s[i] == 16'd0) &&
          !((arb_q != ST_ARB) && (grant_q == 2'(i)))) begin
        comp_found_s = 1'b1;
        comp_ch_s    = 2'(i);
      end else begin
        comp_found_s = comp_found_s;
      end
    end
    for (int i = 0; i < g_NUM_CH; i++) begin
      int_dma_d[i] = comp_found_s && (comp_ch_s == 2'(i));
    end
    if (comp_found_s) begin
      ch_state_d[comp_ch_s] = CH_IDLE;
      cur_idx_d[comp_ch_s]  = (cur_idx_q[comp_ch_s] == LP_LAST_BUF) ? 2'd0 :
                              cur_idx_q[comp_ch_s] + 2'd1;
      fs_valid_d = 1'b1;
      fs_ch_d    = comp_ch_s;
      fs_size_d  = byte_cnt_q[comp_ch_s];
    end else begin
      fs_valid_d = 1'b0;
    end
  end

  // State registers and registered outputs.
  always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
    if (!aclk_rstn_i) begin
      arb_q          <= ST_ARB;
      grant_q        <= 2'd0;
      last_grant_q   <= LP_LAST_CH;
      beats_q        <= 9'd0;
      write_req_q    <= 1'b0;
      write_length_q <= 8'd0;
      write_addr_q   <= 38'd0;
      write_ch_q     <= 2'd0;
      fs_valid_q     <= 1'b0;
      fs_ch_q        <= 2'd0;
      fs_size_q      <= 32'd0;
      int_dma_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        ch_state_q[i] <= CH_IDLE;
        addr_q[i]     <= 38'd0;
        byte_cnt_q[i] <= 32'd0;
        cur_idx_q[i]  <= 2'd0;
        for (int j = 0; j < 4; j++) begin
          base_q[i][j] <= 32'd0;
        end
      end
    end else begin
      arb_q          <= arb_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      beats_q        <= beats_d;
      write_req_q    <= write_req_d;
      write_length_q <= write_length_d;
      write_addr_q   <= write_addr_d;
      write_ch_q     <= write_ch_d;
      fs_valid_q     <= fs_valid_d;
      fs_ch_q        <= fs_ch_d;
      fs_size_q      <= fs_size_d;
      int_dma_q      <= int_dma_d;
      for (int i = 0; i < 4; i++) begin
        ch_state_q[i] <= ch_state_d[i];
        addr_q[i]     <= addr_d[i];
        byte_cnt_q[i] <= byte_cnt_d[i];
        cur_idx_q[i]  <= cur_idx_d[i];
        for (int j = 0; j < 4; j++) begin
          base_q[i][j] <= base_d[i][j];
        end
      end
    end
  end

  assign write_req_o        = write_req_q;
  assign write_length_o     = write_length_q;
  assign write_start_addr_o = write_addr_q;
  assign write_ch_o         = write_ch_q;
  assign frame_size_valid_o = fs_valid_q;
  assign frame_size_ch_o    = fs_ch_q;
  assign frame_size_o       = fs_size_q;
  assign int_dma_o          = int_dma_q;

endmodule

// File: tb/tb_vdma_write_mc_sched.sv
// Scoreboard bench for vdma_write_mc_sched: stimulus queues expected bursts and
// frame reports, a monitor pops and compares them as the DUT presents them.
module tb_vdma_write_mc_sched;
  logic        aclk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  f_start = 2'b00;
  logic [1:0]  f_end = 2'b00;
  logic [31:0] level = 32'd0;
  logic        b_wr = 1'b0;
  logic [1:0]  b_ch = 2'd0;
  logic [1:0]  b_idx = 2'd0;
  logic [31:0] b_data = 32'd0;
  logic        ackn = 1'b0;
  logic        done = 1'b0;
  logic        write_req_o;
  logic [7:0]  write_length_o;
  logic [37:0] write_start_addr_o;
  logic [1:0]  write_ch_o;
  logic        frame_size_valid_o;
  logic [1:0]  frame_size_ch_o;
  logic [31:0] frame_size_o;
  logic [1:0]  int_dma_o;
  logic [3:0]  cur_buff_idx_o;

  typedef struct packed {logic [1:0] ch; logic [7:0] len; logic [37:0] addr;} burst_t;
  typedef struct packed {logic [1:0] ch; logic [31:0] size;} comp_t;
  burst_t exp_b_q[$];
  comp_t  exp_c_q[$];
  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  vdma_write_mc_sched dut (
    .aclk_i(aclk), .aclk_rstn_i(rstn), .vdma_ip_en_i(en),
    .ch_frame_start_i(f_start), .ch_frame_end_i(f_end), .ch_level_i(level),
    .buff_base_wr_i(b_wr), .buff_base_ch_i(b_ch), .buff_base_idx_i(b_idx),
    .buff_base_data_i(b_data), .write_ackn_i(ackn), .write_done_i(done),
    .write_req_o(write_req_o), .write_length_o(write_length_o),
    .write_start_addr_o(write_start_addr_o), .write_ch_o(write_ch_o),
    .frame_size_valid_o(frame_size_valid_o), .frame_size_ch_o(frame_size_ch_o),
    .frame_size_o(frame_size_o), .int_dma_o(int_dma_o), .cur_buff_idx_o(cur_buff_idx_o)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: request stability, handshake contents and frame reports.
  logic        req_prev = 1'b0;
  logic        hs_prev = 1'b0;
  logic [47:0] cap = 48'd0;
  always begin
    burst_t eb;
    comp_t  ec;
    logic [1:0] m;
    @(negedge aclk);
    if (!rstn) begin
      req_prev = 1'b0;
      hs_prev  = 1'b0;
    end else begin
      if (hs_prev) check("req_drop_after_ack", {63'd0, write_req_o}, 64'd0);
      if (write_req_o && req_prev)
        check("req_stable", {16'd0, write_ch_o, write_length_o, write_start_addr_o}, {16'd0, cap});
      if (write_req_o && !req_prev) cap = {write_ch_o, write_length_o, write_start_addr_o};
      if (write_req_o && ackn) begin
        if (exp_b_q.size() == 0) begin
          total++; bad++;
          $display("FAIL burst_unexpected: ch=%0d addr=0x%0h", write_ch_o, write_start_addr_o);
        end else begin
          eb = exp_b_q.pop_front();
          check("burst_ch", {62'd0, write_ch_o}, {62'd0, eb.ch});
          check("burst_len", {56'd0, write_length_o}, {56'd0, eb.len});
          check("burst_addr", {26'd0, write_start_addr_o}, {26'd0, eb.addr});
        end
      end
      hs_prev  = write_req_o && ackn;
      req_prev = write_req_o;
      if (frame_size_valid_o) begin
        if (exp_c_q.size() == 0) begin
          total++; bad++;
          $display("FAIL frame_unexpected: ch=%0d size=%0d", frame_size_ch_o, frame_size_o);
        end else begin
          ec = exp_c_q.pop_front();
          m  = 2'b01 << ec.ch;
          check("frame_ch", {62'd0, frame_size_ch_o}, {62'd0, ec.ch});
          check("frame_size", {32'd0, frame_size_o}, {32'd0, ec.size});
          check("int_dma", {62'd0, int_dma_o}, {62'd0, m});
        end
      end else if (int_dma_o != 2'b00) begin
        total++; bad++;
        $display("FAIL int_dma_alone: got 0x%0h, want 0x0", int_dma_o);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_level(input int ch, input int v);
    level[16*ch +: 16] = 16'(v);
  endtask

  task automatic pulse(input logic [1:0] s, input logic [1:0] e);
    f_start = s; f_end = e;
    tick();
    f_start = 2'b00; f_end = 2'b00;
  endtask

  task automatic wr_base(input int ch, input int idx, input logic [31:0] d);
    b_wr = 1'b1; b_ch = 2'(ch); b_idx = 2'(idx); b_data = d;
    tick();
    b_wr = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!write_req_o && n < 200) begin tick(); n++; end
    if (!write_req_o) begin
      total++; bad++;
      $display("FAIL req_timeout: write_req_o stayed 0 for 200 cycles");
    end
  endtask

  task automatic serve(input int ch, input int len, input logic [37:0] addr, input int dly, input int post_lvl);
    burst_t b;
    b.ch = 2'(ch); b.len = 8'(len); b.addr = addr;
    exp_b_q.push_back(b);
    wait_req();
    repeat (dly) tick();
    ackn = 1'b1; tick(); ackn = 1'b0;
    tick();
    done = 1'b1; set_level(ch, post_lvl); tick(); done = 1'b0;
  endtask

  task automatic expect_frame(input int ch, input int size);
    comp_t c;
    c.ch = 2'(ch); c.size = 32'(size);
    exp_c_q.push_back(c);
  endtask

  task automatic wait_frames();
    int n = 0;
    while (exp_c_q.size() != 0 && n < 100) begin tick(); n++; end
    check("frames_pending", 64'(exp_c_q.size()), 64'd0);
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_req", {63'd0, write_req_o}, 64'd0);
    check("rst_req_fields", {16'd0, write_ch_o, write_length_o, write_start_addr_o}, 64'd0);
    check("rst_frame", {29'd0, frame_size_valid_o, frame_size_ch_o, frame_size_o}, 64'd0);
    check("rst_int_idx", {58'd0, int_dma_o, cur_buff_idx_o}, 64'd0);
    rstn = 1'b1;
    tick();
    wr_base(0, 0, 32'h1000_0000); wr_base(0, 1, 32'h2000_0000); wr_base(0, 2, 32'h3000_0000);
    wr_base(1, 0, 32'h4000_0000); wr_base(1, 1, 32'h5000_0000); wr_base(1, 2, 32'h6000_0000);
    wr_base(1, 3, 32'hDEAD_0000); wr_base(2, 0, 32'hBAD0_0000);
    en = 1'b1;

    // Single channel: two full bursts, then a short flush burst.
    set_level(0, 16);
    pulse(2'b01, 2'b00);
    serve(0, 15, 38'h00_1000_0000, 10, 16);
    serve(0, 15, 38'h00_1000_0080, 0, 5);
    repeat (4) tick();
    check("no_req_partial", {63'd0, write_req_o}, 64'd0);
    expect_frame(0, 296);
    pulse(2'b00, 2'b01);
    serve(0, 4, 38'h00_1000_0100, 0, 0);
    wait_frames();
    check("idx_after_f1", {60'd0, cur_buff_idx_o}, 64'h1);

    // Two channels alternate, then finish together.
    set_level(0, 32); set_level(1, 32);
    pulse(2'b11, 2'b00);
    serve(1, 15, 38'h00_4000_0000, 0, 32);
    serve(0, 15, 38'h00_2000_0000, 0, 32);
    serve(1, 15, 38'h00_4000_0080, 0, 0);
    serve(0, 15, 38'h00_2000_0080, 0, 0);
    expect_frame(0, 256);
    expect_frame(1, 256);
    pulse(2'b00, 2'b11);
    wait_frames();
    check("idx_after_dual", {60'd0, cur_buff_idx_o}, 64'h6);

    // Start and end ignored when disabled and idle.
    en = 1'b0;
    set_level(1, 3);
    pulse(2'b10, 2'b00);
    repeat (4) tick();
    pulse(2'b00, 2'b10);
    repeat (6) tick();
    check("disabled_no_req", {63'd0, write_req_o}, 64'd0);
    check("disabled_idx", {60'd0, cur_buff_idx_o}, 64'h6);
    en = 1'b1;

    // Simultaneous start+end in idle acts as start only.
    set_level(1, 0);
    pulse(2'b10, 2'b10);
    repeat (5) tick();
    set_level(1, 3);
    repeat (4) tick();
    check("start_end_active", {63'd0, write_req_o}, 64'd0);
    expect_frame(1, 24);
    pulse(2'b00, 2'b10);
    serve(1, 2, 38'h00_5000_0000, 0, 0);
    wait_frames();
    check("idx_ch1_2", {60'd0, cur_buff_idx_o}, 64'hA);

    // Enable dropped mid-frame: frame still completes.
    set_level(1, 3);
    pulse(2'b10, 2'b00);
    en = 1'b0;
    expect_frame(1, 24);
    pulse(2'b00, 2'b10);
    serve(1, 2, 38'h00_6000_0000, 0, 0);
    wait_frames();
    check("idx_ch1_wrap", {60'd0, cur_buff_idx_o}, 64'h2);
    en = 1'b1;

    // Fourth frame reuses the idx0 base.
    set_level(1, 3);
    pulse(2'b10, 2'b00);
    expect_frame(1, 24);
    pulse(2'b00, 2'b10);
    serve(1, 2, 38'h00_4000_0000, 0, 0);
    wait_frames();
    check("idx_ch1_1", {60'd0, cur_buff_idx_o}, 64'h6);

    // Reset while waiting for burst completion.
    set_level(0, 16);
    pulse(2'b01, 2'b00);
    begin
      burst_t b;
      b.ch = 2'd0; b.len = 8'd15; b.addr = 38'h00_3000_0000;
      exp_b_q.push_back(b);
    end
    wait_req();
    ackn = 1'b1; tick(); ackn = 1'b0;
    tick();
    rstn = 1'b0;
    level = 32'd0;
    #1;
    check("midrst_req", {16'd0, write_req_o, write_ch_o, write_length_o, write_start_addr_o}, 64'd0);
    check("midrst_frame", {29'd0, frame_size_valid_o, frame_size_ch_o, frame_size_o}, 64'd0);
    check("midrst_int_idx", {58'd0, int_dma_o, cur_buff_idx_o}, 64'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (10) tick();
    check("postrst_idle", {63'd0, write_req_o}, 64'd0);

    // Base table was cleared: next frame starts at address 0.
    set_level(0, 16);
    pulse(2'b01, 2'b00);
    serve(0, 15, 38'd0, 0, 0);
    expect_frame(0, 128);
    pulse(2'b00, 2'b01);
    wait_frames();
    check("postrst_idx", {60'd0, cur_buff_idx_o}, 64'h1);
    check("bursts_pending", 64'(exp_b_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
